psr_deser: RTL and testbench
============================

# psr_deser

Serial-to-parallel receiver that terminates a parallel-shift-register transmit chain. Accepts a framed, bit-qualified serial stream, assembles `WIDTH`-bit words in a shift register, and presents each complete word on a held parallel output with a valid/ready handshake. Sits at the far end of the serial link and feeds a word-level consumer. Detects overrun and framing errors.

## Interface
Parameters:
- `WIDTH`, 8: word length in bits; legal range is `WIDTH` ≥ 2.
- `MSB_FIRST`, 1: 1 means the first serial bit lands in `pout[WIDTH-1]`; 0 means it lands in `pout[0]`.

Ports:
- `clk` input 1: the single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sin` input 1: serial data bit.
- `sin_valid` input 1: `sin` is sampled only when this is high.
- `sin_sof` input 1: start of frame; qualified by `sin_valid`; marks the current bit as bit 0 of a word.
- `pout` output `WIDTH`: assembled word.
- `pout_valid` output 1: `pout` holds an unconsumed word.
- `pout_ready` input 1: consumer accepts `pout` on a cycle where `pout_valid && pout_ready`.
- `overrun` output 1: one-cycle pulse; a completed word was dropped.
- `frame_err` output 1: one-cycle pulse; `sin_sof` arrived mid-word.

## Operation
- States: HUNT and SHIFT. Reset state is HUNT.
- HUNT:
  - Bits without `sin_sof` are ignored.
  - `sin_valid && sin_sof` captures the bit, sets `bit_cnt`=1, and moves to SHIFT.
- SHIFT:
  - Each `sin_valid` cycle shifts `sin` in and increments `bit_cnt`.
  - `sin_valid` low is a gap: no state change and no timeout.
- Word completion:
  - Completion is the valid bit taken while `bit_cnt == WIDTH-1`.
  - That same edge loads the assembled word, including the incoming bit, into the output register, then moves to HUNT and clears `bit_cnt`.
- `sin_sof` during SHIFT:
  - The partial word is discarded and `frame_err` pulses.
  - The current bit becomes bit 0, `bit_cnt`=1, and the state stays SHIFT.
  - If the state is SHIFT with `bit_cnt == WIDTH-1` and `sin_sof` arrives, SOF wins: restart, `frame_err` pulses, and no word completes.
- Output register:
  - `pout` is held stable while `pout_valid` is high and not consumed.
  - `pout_valid` clears on consume unless a new word loads on the same edge; in that case the new word loads and `pout_valid` stays high.
- Completion while `pout_valid && !pout_ready`:
  - The new word is dropped, `pout` is unchanged, and `overrun` pulses.
  - The receiver still returns to HUNT.
- `bit_cnt` width is `$clog2(WIDTH)`; it never wraps past `WIDTH-1`.
- Reset values:
  - `pout`=0, `pout_valid`=0, `overrun`=0, `frame_err`=0.
  - Shift register is 0, `bit_cnt`=0, state is HUNT.
- Reset mid-word or mid-hold discards everything. The first post-reset word needs a fresh `sin_sof`.

## Timing
- Latency: `pout_valid` rises in the cycle after the edge that samples the last bit.
- Throughput: one bit per cycle. Back-to-back words are sustained: the SOF of word N+1 may arrive in the cycle immediately after the last bit of word N.
- `overrun` and `frame_err` are registered. Each is high for exactly the cycle after the offending edge.
- No combinational path from `sin*` to any output. `pout_ready` affects only registered state.

## Structure
- Shared package `psr_pkg` holds:
  - `psr_state_t` enum (HUNT, SHIFT);
  - `PSR_WIDTH_DEFAULT`.
- Sub-module `psr_out_buf` is the `WIDTH`-bit holding register with valid/ready handshake and overrun detection.
- The top level keeps the FSM, bit counter and shift register.

## Test plan
- `WIDTH`=8, `MSB_FIRST`=1, `pout_ready`=1:
  - Stimulus: send bits 1,0,1,0,0,1,0,1 consecutively, with SOF on the first bit.
  - Response: `pout_valid` high for one cycle, one cycle after bit 8, with `pout`=0xA5.
- Same word 0xA5 with `sin_valid` low for 3 cycles between bits 4 and 5:
  - `pout`=0xA5 arrives 3 cycles later than in the first case.
  - No `frame_err`.
- `MSB_FIRST`=0, same bit sequence → `pout`=0xA5 reversed = 0xA5; repeat with sequence 1,1,0,0,0,0,0,0 → `pout`=0x03.
- `pout_ready`=0, send 0x3C then 0xC3 back-to-back:
  - `pout` stays 0x3C and `overrun` pulses once after the last bit of 0xC3.
  - Raising `pout_ready` consumes 0x3C, then `pout_valid` drops.
- Send 5 bits, then SOF plus 8 bits of 0x81:
  - `frame_err` pulses once, then `pout`=0x81.
- Assert `rst` for 1 cycle after 4 bits, then send 8 bits without SOF:
  - All outputs read 0.
  - No word is produced.

Source files
------------

// File: rtl/psr_pkg.sv
// rtl/psr_pkg.sv - shared types and defaults for the serial-to-parallel receiver
package psr_pkg;

    typedef enum logic {
        HUNT  = 1'b0,
        SHIFT = 1'b1
    } psr_state_t;

    localparam int PSR_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/psr_out_buf.sv
// rtl/psr_out_buf.sv - word holding register with valid/ready handshake and overrun detection
module psr_out_buf
    import psr_pkg::*;
#(
    parameter int WIDTH = PSR_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ready,
    output logic             overrun
);

    // A new word may enter when the slot is empty or being consumed this edge;
    // otherwise it is dropped and the held word stays untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            data    <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                if (!valid || ready) begin
                    data  <= load_data;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/psr_deser.sv
// rtl/psr_deser.sv - framed serial receiver assembling WIDTH-bit words
module psr_deser
    import psr_pkg::*;
#(
    parameter int WIDTH     = PSR_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_sof,
    output logic [WIDTH-1:0] pout,
    output logic             pout_valid,
    input  logic             pout_ready,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    psr_state_t       state;
    psr_state_t       next_state;
    logic [CW-1:0]    bit_cnt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] first_word;
    logic             start;
    logic             advance;
    logic             complete;
    logic             restart_err;

    // Shift direction decides which end of the word the first bit ends up in.
    always_comb begin
        shifted    = '0;
        first_word = '0;
        if (MSB_FIRST) begin
            shifted    = {shreg[WIDTH-2:0], sin};
            first_word = {{(WIDTH-1){1'b0}}, sin};
        end else begin
            shifted    = {sin, shreg[WIDTH-1:1]};
            first_word = {sin, {(WIDTH-1){1'b0}}};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
        end else begin
            state <= next_state;
        end
    end

    // Next state and datapath controls; SOF always takes priority over completion.
    always_comb begin
        next_state  = state;
        start       = 1'b0;
        advance     = 1'b0;
        complete    = 1'b0;
        restart_err = 1'b0;
        case (state)
            HUNT: begin
                if (sin_valid && sin_sof) begin
                    start      = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (sin_valid) begin
                    if (sin_sof) begin
                        start       = 1'b1;
                        restart_err = 1'b1;
                    end else if (bit_cnt == LAST_BIT) begin
                        complete   = 1'b1;
                        next_state = HUNT;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: next_state = HUNT;
        endcase
    end

    // Shift register, bit counter and the registered framing-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            bit_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= restart_err;
            if (start) begin
                shreg   <= first_word;
                bit_cnt <= CW'(1);
            end else if (advance) begin
                shreg   <= shifted;
                bit_cnt <= bit_cnt + CW'(1);
            end else if (complete) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end
        end
    end

    psr_out_buf #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (complete),
        .load_data(shifted),
        .data     (pout),
        .valid    (pout_valid),
        .ready    (pout_ready),
        .overrun  (overrun)
    );

endmodule

// File: tb/tb_psr_deser.sv
// tb/tb_psr_deser.sv - self-checking bench for psr_deser, both bit orders
module tb_psr_deser;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         sin;
    logic         sin_valid;
    logic         sin_sof;
    logic         pout_ready;
    logic [W-1:0] pout_m;
    logic [W-1:0] pout_l;
    logic         pv_m, pv_l, ov_m, ov_l, fe_m, fe_l;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psr_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof),
        .pout(pout_m), .pout_valid(pv_m), .pout_ready(pout_ready),
        .overrun(ov_m), .frame_err(fe_m)
    );

    psr_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_sof(sin_sof),
        .pout(pout_l), .pout_valid(pv_l), .pout_ready(pout_ready),
        .overrun(ov_l), .frame_err(fe_l)
    );

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: collects the bits of the current frame in a queue and
    // builds the word arithmetically once WIDTH bits have been gathered.
    bit           mq[$];
    bit           m_active = 1'b0;
    logic [W-1:0] e_pout_m = '0;
    logic [W-1:0] e_pout_l = '0;
    bit           e_valid = 1'b0;
    bit           e_ovr = 1'b0;
    bit           e_ferr = 1'b0;
    bit           chk_en = 1'b0;

    // Advance the model on each rising edge from the inputs presented to it.
    always @(posedge clk) begin : model
        bit           consume;
        bit           done;
        logic [W-1:0] wm;
        logic [W-1:0] wl;
        if (rst) begin
            mq.delete();
            m_active = 1'b0;
            e_pout_m = '0;
            e_pout_l = '0;
            e_valid  = 1'b0;
            e_ovr    = 1'b0;
            e_ferr   = 1'b0;
            chk_en   = 1'b1;
        end else begin
            consume = e_valid && pout_ready;
            done    = 1'b0;
            e_ovr   = 1'b0;
            e_ferr  = 1'b0;
            if (sin_valid) begin
                if (sin_sof) begin
                    if (m_active) e_ferr = 1'b1;
                    mq.delete();
                    mq.push_back(sin);
                    m_active = 1'b1;
                end else if (m_active) begin
                    mq.push_back(sin);
                    if (mq.size() == W) begin
                        done     = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end
            if (done) begin
                wm = '0;
                wl = '0;
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = mq[i];
                    wl[i]     = mq[i];
                end
                mq.delete();
                if (e_valid && !pout_ready) begin
                    e_ovr = 1'b1;
                end else begin
                    e_pout_m = wm;
                    e_pout_l = wl;
                    e_valid  = 1'b1;
                end
            end else if (consume) begin
                e_valid = 1'b0;
            end
        end
    end

    // Compare both DUTs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pout_msb",  32'(pout_m), 32'(e_pout_m));
            check("pout_lsb",  32'(pout_l), 32'(e_pout_l));
            check("valid_msb", 32'(pv_m),   32'(e_valid));
            check("valid_lsb", 32'(pv_l),   32'(e_valid));
            check("ovr_msb",   32'(ov_m),   32'(e_ovr));
            check("ovr_lsb",   32'(ov_l),   32'(e_ovr));
            check("ferr_msb",  32'(fe_m),   32'(e_ferr));
            check("ferr_lsb",  32'(fe_l),   32'(e_ferr));
        end
    end

    task automatic cyc(bit v, bit b, bit s);
        sin_valid = v;
        sin       = b;
        sin_sof   = s;
        @(negedge clk);
    endtask

    task automatic send_word(logic [7:0] w);
        for (int i = 7; i >= 0; i--) cyc(1'b1, w[i], i == 7);
    endtask

    initial begin
        logic [7:0] w;
        bit         fe_any;
        rst        = 1'b1;
        sin        = 1'b0;
        sin_valid  = 1'b0;
        sin_sof    = 1'b0;
        pout_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_pout",  32'(pout_m), 32'h0);
        check("rst_valid", 32'(pv_m),   32'h0);
        check("rst_ovr",   32'(ov_m),   32'h0);
        check("rst_ferr",  32'(fe_m),   32'h0);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        // Plain word, consumer always ready.
        send_word(8'hA5);
        check("t1_valid", 32'(pv_m),   32'h1);
        check("t1_pout",  32'(pout_m), 32'hA5);
        cyc(1'b0, 1'b0, 1'b0);
        check("t1_single", 32'(pv_m), 32'h0);

        // Same word with a three-cycle gap after bit 4.
        w = 8'hA5;
        fe_any = 1'b0;
        for (int i = 7; i >= 4; i--) begin
            cyc(1'b1, w[i], i == 7);
            fe_any |= fe_m;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            fe_any |= fe_m;
        end
        for (int i = 3; i >= 1; i--) begin
            cyc(1'b1, w[i], 1'b0);
            fe_any |= fe_m;
        end
        check("t2_early", 32'(pv_m), 32'h0);
        cyc(1'b1, w[0], 1'b0);
        check("t2_valid", 32'(pv_m),   32'h1);
        check("t2_pout",  32'(pout_m), 32'hA5);
        check("t2_ferr",  32'(fe_any), 32'h0);

        // LSB-first ordering.
        send_word(8'hA5);
        check("t3_lsb_a5", 32'(pout_l), 32'hA5);
        send_word(8'hC0);
        check("t3_lsb_03", 32'(pout_l), 32'h03);
        check("t3_msb_c0", 32'(pout_m), 32'hC0);
        cyc(1'b0, 1'b0, 1'b0);

        // Overrun with a stalled consumer.
        pout_ready = 1'b0;
        send_word(8'h3C);
        check("t4_first",  32'(pout_m), 32'h3C);
        check("t4_noovr",  32'(ov_m),   32'h0);
        send_word(8'hC3);
        check("t4_ovr",    32'(ov_m),   32'h1);
        check("t4_held",   32'(pout_m), 32'h3C);
        check("t4_hvalid", 32'(pv_m),   32'h1);
        pout_ready = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        check("t4_drain",  32'(pv_m), 32'h0);
        check("t4_ovr1",   32'(ov_m), 32'h0);

        // Framing error: SOF after five bits restarts the word.
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        w = 8'h81;
        for (int i = 7; i >= 0; i--) begin
            cyc(1'b1, w[i], i == 7);
            if (i == 7) check("t5_ferr",  32'(fe_m), 32'h1);
            if (i == 6) check("t5_ferr1", 32'(fe_m), 32'h0);
        end
        check("t5_pout",  32'(pout_m), 32'h81);
        check("t5_valid", 32'(pv_m),   32'h1);
        cyc(1'b0, 1'b0, 1'b0);

        // Reset mid-word, then bits without SOF produce nothing.
        cyc(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        check("t6_pout",  32'(pout_m), 32'h0);
        check("t6_poutl", 32'(pout_l), 32'h0);
        check("t6_valid", 32'(pv_m),   32'h0);

        // Randomized traffic checked every cycle by the model.
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 599) == 0);
            pout_ready = 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom_range(0, 10) == 0);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
